// File: rtl/keypad_pkg.sv
// Shared constants, key codes and FSM state type for the keypad entry block.
package keypad_pkg;

  localparam int KEYS = 12;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  typedef enum logic [1:0] {
    RELEASE_WAIT = 2'd0,
    IDLE         = 2'd1,
    PRESSED      = 2'd2
  } state_t;

  // Bit position of the highest set bit; only meaningful for one-hot maps.
  function automatic logic [3:0] key_index(input logic [KEYS-1:0] map);
    logic [3:0] idx;
    idx = '0;
    for (int k = 0; k < KEYS; k++) begin
      if (map[k]) idx = 4'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Generic en-strobed debouncer: a bitmap becomes stable after DEBOUNCE
// consecutive identical samples.
module keypad_debounce #(
  parameter int WIDTH    = 12,
  parameter int DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  logic [WIDTH-1:0] prev;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             same;

  // The counter tracks matches after the first sample of a run, so reaching
  // CNT_MAX means DEBOUNCE identical samples including the current one.
  always_comb begin
    same     = (raw == prev);
    cnt_next = '0;
    if (same) begin
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else if (en) begin
      prev <= raw;
      cnt  <= cnt_next;
      if (same && (cnt_next == CNT_MAX)) stable <= raw;
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: debounced key events, 4-digit BCD entry buffer with
// backspace ('*') and commit ('#'), driving the 7-segment display inputs.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [9:0]            numbers,
  input  logic                  asterisk,
  input  logic                  hash,
  output logic                  key_valid,
  output logic [3:0]            key_code,
  output logic [4*DIGITS-1:0]   hexx,
  output logic [DIGITS-1:0]     mask,
  output logic [DIGITS-1:0]     points,
  output logic [4*DIGITS-1:0]   value,
  output logic                  value_valid,
  output logic                  err,
  output logic [1:0]            dbg_state
);

  localparam int CNTW = $clog2(DIGITS + 1);
  localparam logic [CNTW-1:0] FULL = CNTW'(DIGITS);

  logic [KEYS-1:0] raw;
  logic [KEYS-1:0] stable;
  logic [KEYS-1:0] pressed_map;
  logic            raw_idle_seen;
  logic            event_fire;
  logic [CNTW-1:0] count;
  state_t          state;
  state_t          state_next;

  assign raw       = {hash, asterisk, numbers};
  assign dbg_state = state;

  keypad_debounce #(
    .WIDTH    (KEYS),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .raw    (raw),
    .stable (stable)
  );

  // Reset forces stable to zero even with a key held, so leaving
  // RELEASE_WAIT also needs a genuinely idle raw sample since reset.
  always_comb begin
    state_next = state;
    event_fire = 1'b0;
    case (state)
      RELEASE_WAIT: begin
        if ((stable == '0) && raw_idle_seen) state_next = IDLE;
      end
      IDLE: begin
        if ($onehot(stable)) begin
          event_fire = 1'b1;
          state_next = PRESSED;
        end else if (stable != '0) begin
          state_next = RELEASE_WAIT;
        end
      end
      PRESSED: begin
        if (stable == '0) state_next = IDLE;
        else if ((stable & ~pressed_map) != '0) state_next = RELEASE_WAIT;
      end
      default: state_next = RELEASE_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RELEASE_WAIT;
      pressed_map   <= '0;
      raw_idle_seen <= 1'b0;
      key_valid     <= 1'b0;
      key_code      <= '0;
    end else begin
      state     <= state_next;
      key_valid <= event_fire;
      if (en && (raw == '0)) raw_idle_seen <= 1'b1;
      if (event_fire) begin
        pressed_map <= stable;
        key_code    <= key_index(stable);
      end
    end
  end

  // Entry buffer: newest digit in the low nibble.
  always_ff @(posedge clk) begin
    if (rst) begin
      hexx        <= '0;
      count       <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      err         <= 1'b0;
      if (key_valid) begin
        if (key_code == KEY_STAR) begin
          if (count != '0) begin
            hexx  <= hexx >> 4;
            count <= count - 1'b1;
          end
        end else if (key_code == KEY_HASH) begin
          if (count != '0) begin
            value       <= hexx;
            value_valid <= 1'b1;
            hexx        <= '0;
            count       <= '0;
          end else begin
            err <= 1'b1;
          end
        end else if (count == FULL) begin
          err <= 1'b1;
        end else begin
          hexx  <= {hexx[4*DIGITS-5:0], key_code};
          count <= count + 1'b1;
        end
      end
    end
  end

  always_comb begin
    mask   = '0;
    points = '0;
    for (int i = 0; i < DIGITS; i++) begin
      mask[i] = (CNTW'(i) < count);
    end
    points[DIGITS-1] = (count == FULL);
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: vector table, hand-written corner sequences and a
// randomized run checked against a sample-history/digit-list model.
module tb_keypad_entry;
  import keypad_pkg::*;

  localparam int DIGITS = 4;
  localparam int DEB    = 3;
  localparam int W      = 4 * DIGITS;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst, en, asterisk, hash;
  logic [9:0] numbers;
  logic key_valid, value_valid, err;
  logic [3:0] key_code;
  logic [W-1:0] hexx, value;
  logic [DIGITS-1:0] mask, points;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  keypad_entry #(.DIGITS(DIGITS), .DEBOUNCE(DEB)) dut (
    .clk(clk), .rst(rst), .en(en), .numbers(numbers), .asterisk(asterisk),
    .hash(hash), .key_valid(key_valid), .key_code(key_code), .hexx(hexx),
    .mask(mask), .points(points), .value(value), .value_valid(value_valid),
    .err(err), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail = 0;
  int n_events = 0;
  int n_err_seen = 0;
  int n_vv_seen = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (key_valid) begin
      n_events++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_key: key_valid with key_code %0h, none expected", key_code);
      end else begin
        check("key_code", 32'(key_code), 32'(exp_q.pop_front()));
      end
    end
    if (err) n_err_seen++;
    if (value_valid) n_vv_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raw(input logic [11:0] r);
    {hash, asterisk, numbers} = r;
  endtask

  function automatic logic [11:0] key_map(input logic [3:0] code);
    logic [11:0] one;
    one = 12'd1;
    return one << code;
  endfunction

  task automatic press(input logic [3:0] code);
    exp_q.push_back(code);
    set_raw(key_map(code));
    repeat (6) step();
    set_raw('0);
    repeat (6) step();
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check(name, 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (4) step();
  endtask

  // ---------------- reference model ----------------
  int m_digits[$];
  logic [W-1:0] m_value;
  int m_err, m_vv, m_events, m_run;
  logic [11:0] m_cur, m_stable;

  function automatic logic [W-1:0] model_hexx();
    logic [W-1:0] h;
    h = '0;
    foreach (m_digits[i]) h = h * 16 + W'(m_digits[i]);
    return h;
  endfunction

  task automatic model_key(input int code);
    if (code < 10) begin
      if (m_digits.size() < DIGITS) m_digits.push_back(code);
      else m_err++;
    end else if (code == 10) begin
      if (m_digits.size() > 0) void'(m_digits.pop_back());
    end else begin
      if (m_digits.size() > 0) begin
        m_value = model_hexx();
        m_vv++;
        m_digits.delete();
      end else begin
        m_err++;
      end
    end
  endtask

  // A stable bitmap needs DEB identical samples in a row; a press counts only
  // when stable moves from all-released straight to a single key.
  task automatic model_cycle(input logic en_v, input logic [11:0] raw_v);
    int code;
    if (en_v) begin
      if (raw_v == m_cur) m_run++;
      else begin
        m_cur = raw_v;
        m_run = 1;
      end
      if (m_run >= DEB && m_stable != m_cur) begin
        if ($countones(m_cur) == 1 && m_stable == '0) begin
          code = 0;
          for (int k = 0; k < 12; k++) if (m_cur[k]) code = k;
          exp_q.push_back(4'(code));
          m_events++;
          model_key(code);
        end
        m_stable = m_cur;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  key;
    logic [15:0] hexx;
    logic [3:0]  mask;
    logic [3:0]  points;
    int          err_d;
    int          vv_d;
    logic [15:0] value;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int n0, e0, v0;
    logic [11:0] r;

    tbl = '{
      '{4'h1, 16'h0001, 4'h1, 4'h0, 0, 0, 16'h0000},
      '{4'h2, 16'h0012, 4'h3, 4'h0, 0, 0, 16'h0000},
      '{4'h3, 16'h0123, 4'h7, 4'h0, 0, 0, 16'h0000},
      '{4'h4, 16'h1234, 4'hF, 4'h8, 0, 0, 16'h0000},
      '{4'h5, 16'h1234, 4'hF, 4'h8, 1, 0, 16'h0000},
      '{4'hA, 16'h0123, 4'h7, 4'h0, 0, 0, 16'h0000},
      '{4'hA, 16'h0012, 4'h3, 4'h0, 0, 0, 16'h0000},
      '{4'hA, 16'h0001, 4'h1, 4'h0, 0, 0, 16'h0000},
      '{4'hA, 16'h0000, 4'h0, 4'h0, 0, 0, 16'h0000},
      '{4'hA, 16'h0000, 4'h0, 4'h0, 0, 0, 16'h0000},
      '{4'h1, 16'h0001, 4'h1, 4'h0, 0, 0, 16'h0000},
      '{4'h2, 16'h0012, 4'h3, 4'h0, 0, 0, 16'h0000},
      '{4'h3, 16'h0123, 4'h7, 4'h0, 0, 0, 16'h0000},
      '{4'hB, 16'h0000, 4'h0, 4'h0, 0, 1, 16'h0123},
      '{4'hB, 16'h0000, 4'h0, 4'h0, 1, 0, 16'h0123},
      '{4'h0, 16'h0000, 4'h1, 4'h0, 0, 0, 16'h0123}
    };

    // reset state
    rst = 1'b1;
    en = 1'b1;
    set_raw('0);
    repeat (3) step();
    check("rst_key_valid", 32'(key_valid), 0);
    check("rst_key_code", 32'(key_code), 0);
    check("rst_hexx", 32'(hexx), 0);
    check("rst_mask", 32'(mask), 0);
    check("rst_points", 32'(points), 0);
    check("rst_value", 32'(value), 0);
    check("rst_value_valid", 32'(value_valid), 0);
    check("rst_err", 32'(err), 0);
    check("rst_state", 32'(dbg_state), 32'(RELEASE_WAIT));
    rst = 1'b0;

    // first press: zeros then key 5 held five samples
    repeat (4) step();
    exp_q.push_back(4'h5);
    set_raw(key_map(4'h5));
    repeat (5) step();
    set_raw('0);
    repeat (6) step();
    wait_drain("first_drain");
    check("first_events", 32'(n_events), 1);
    check("first_hexx", 32'(hexx), 32'h0005);
    check("first_mask", 32'(mask), 32'h1);

    // table-driven buffer sequence
    do_reset();
    for (int i = 0; i < 16; i++) begin
      e0 = n_err_seen;
      v0 = n_vv_seen;
      press(tbl[i].key);
      check($sformatf("vec%0d_hexx", i), 32'(hexx), 32'(tbl[i].hexx));
      check($sformatf("vec%0d_mask", i), 32'(mask), 32'(tbl[i].mask));
      check($sformatf("vec%0d_points", i), 32'(points), 32'(tbl[i].points));
      check($sformatf("vec%0d_err", i), 32'(n_err_seen - e0), 32'(tbl[i].err_d));
      check($sformatf("vec%0d_vv", i), 32'(n_vv_seen - v0), 32'(tbl[i].vv_d));
      check($sformatf("vec%0d_value", i), 32'(value), 32'(tbl[i].value));
    end
    wait_drain("table_drain");

    // bouncing key 7, then a clean 3-sample hold
    n0 = n_events;
    for (int k = 0; k < 8; k++) begin
      set_raw((k % 2 == 0) ? key_map(4'h7) : 12'h000);
      step();
    end
    check("bounce_no_event", 32'(n_events), 32'(n0));
    exp_q.push_back(4'h7);
    set_raw(key_map(4'h7));
    repeat (3) step();
    set_raw('0);
    repeat (6) step();
    wait_drain("bounce_drain");
    check("bounce_one_event", 32'(n_events), 32'(n0 + 1));

    // sparse en: three en-samples required, not three clocks
    n0 = n_events;
    set_raw(key_map(4'h6));
    for (int j = 0; j < 2; j++) begin
      en = 1'b1;
      step();
      en = 1'b0;
      repeat (3) step();
    end
    check("en_two_samples", 32'(n_events), 32'(n0));
    exp_q.push_back(4'h6);
    en = 1'b1;
    step();
    en = 1'b0;
    repeat (3) step();
    en = 1'b1;
    set_raw('0);
    repeat (6) step();
    wait_drain("en_drain");
    check("en_three_samples", 32'(n_events), 32'(n0 + 1));

    // two keys together, partial release, full release, clean press
    n0 = n_events;
    set_raw(key_map(4'h1) | key_map(4'h2));
    repeat (6) step();
    set_raw(key_map(4'h2));
    repeat (6) step();
    set_raw('0);
    repeat (6) step();
    check("multi_no_event", 32'(n_events), 32'(n0));
    press(4'h2);
    wait_drain("multi_drain");
    check("multi_then_press", 32'(n_events), 32'(n0 + 1));

    // key held through reset
    exp_q.push_back(4'h9);
    set_raw(key_map(4'h9));
    repeat (6) step();
    wait_drain("hold_pre_drain");
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    check("rst_mid_hexx", 32'(hexx), 0);
    check("rst_mid_mask", 32'(mask), 0);
    n0 = n_events;
    repeat (10) step();
    check("held_through_reset", 32'(n_events), 32'(n0));
    set_raw('0);
    repeat (6) step();
    press(4'h9);
    wait_drain("rehold_drain");
    check("repress_hexx", 32'(hexx), 32'h0009);
    check("repress_mask", 32'(mask), 32'h1);

    // randomized run against the model
    do_reset();
    m_digits.delete();
    m_value = '0;
    m_err = 0;
    m_vv = 0;
    m_events = 0;
    m_cur = '0;
    m_run = DEB;
    m_stable = '0;
    e0 = n_err_seen;
    v0 = n_vv_seen;
    n0 = n_events;
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4, 5, 6, 7, 8, 9: r = '0;
        10, 11, 12, 13, 14, 15, 16: r = key_map(4'($urandom_range(0, 11)));
        default: r = key_map(4'($urandom_range(0, 11))) | key_map(4'($urandom_range(0, 11)));
      endcase
      for (int h = $urandom_range(1, 6); h > 0; h--) begin
        en = ($urandom_range(0, 3) != 0);
        set_raw(r);
        model_cycle(en, r);
        step();
      end
    end
    en = 1'b1;
    set_raw('0);
    for (int i = 0; i < 8; i++) begin
      model_cycle(1'b1, '0);
      step();
    end
    wait_drain("rand_drain");
    check("rand_events", 32'(n_events - n0), 32'(m_events));
    check("rand_hexx", 32'(hexx), 32'(model_hexx()));
    check("rand_mask", 32'(mask), (32'd1 << m_digits.size()) - 32'd1);
    check("rand_points", 32'(points), (m_digits.size() == DIGITS) ? 32'h8 : 32'h0);
    check("rand_value", 32'(value), 32'(m_value));
    check("rand_err", 32'(n_err_seen - e0), 32'(m_err));
    check("rand_vv", 32'(n_vv_seen - v0), 32'(m_vv));

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Consumer of the 3x4 keypad scanner's key bitmap (numbers[9:0], asterisk, hash).
- Debounces the bitmap and turns it into single key-press events.
- Keeps a 4-digit BCD entry buffer and drives hexx/mask/points into the 4-digit 7-segment display driver.
- Commits the entered number on '#'; '*' is backspace.

Parameters:
- DIGITS, 4: entry buffer depth in digits; hexx/mask/points widths follow from it.
- DEBOUNCE, 3: number of consecutive identical en-samples required before a bitmap counts as stable (must be ≥1).

Ports:
- clk  input  1  block clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sample strobe; bitmap inputs are sampled only on cycles with en=1.
- numbers  input  10  scanner bitmap; bit k=1 means digit key k is pressed.
- asterisk  input  1  '*' key pressed.
- hash  input  1  '#' key pressed.
- key_valid  output  1  one-cycle pulse per accepted key press.
- key_code  output  4  code of the accepted key: 0x0-0x9 digits, 0xA '*', 0xB '#'; valid with key_valid.
- hexx  output  4*DIGITS  entry buffer, BCD, most recent digit in [3:0].
- mask  output  DIGITS  mask[i]=1 means display digit i is lit.
- points  output  DIGITS  decimal points; points[DIGITS-1]=1 while the buffer is full, all other bits 0.
- value  output  4*DIGITS  last committed number; holds until the next commit.
- value_valid  output  1  one-cycle pulse when value is updated.
- err  output  1  one-cycle pulse on a rejected operation.

Behaviour:
- Reset values:
  - key_valid=0, key_code=0, hexx=0, mask=0, points=0, value=0, value_valid=0, err=0.
  - Digit count=0, stable bitmap=0, debounce counter=0, FSM=RELEASE_WAIT.
- Debounce (en=1 cycles only):
  - raw = {hash, asterisk, numbers}.
  - If raw equals the previous sample, the counter increments, saturating at DEBOUNCE-1; otherwise the counter clears to 0.
  - When the counter is at DEBOUNCE-1 and raw still matches, stable <= raw.
  - en=0 cycles freeze all debounce state.
- FSM, evaluated on stable each cycle:
  - RELEASE_WAIT: go to IDLE when stable==0. No events are generated in this state.
  - IDLE:
    - stable has exactly one bit set: emit the event, go to PRESSED.
    - stable has ≥2 bits set: go to RELEASE_WAIT with no event.
  - PRESSED:
    - stable==0: go to IDLE.
    - stable gains any additional bit: go to RELEASE_WAIT with no event.
    - Holding the same key never repeats the event.
- Event timing:
  - key_valid/key_code are registered one cycle after the stable update.
  - Buffer effects (hexx, mask, points, value, value_valid, err) are visible one cycle after key_valid.
- Digit 0-9:
  - count<DIGITS: hexx <= {hexx[4*DIGITS-5:0], code}, count++.
  - count==DIGITS: buffer unchanged, err pulse.
- '*':
  - count>0: hexx <= hexx>>4, count--.
  - count==0: no change, no err.
- '#':
  - count>0: value<=hexx, value_valid pulse, then hexx=0 and count=0.
  - count==0: err pulse, value unchanged.
- mask[i] = (i < count). Display of leading zeros follows mask only.
- Reset mid-operation: everything returns to reset values. A key held through reset produces no event until it is released and pressed again, because the FSM restarts in RELEASE_WAIT.
- Event and raw-input change in the same cycle: the event completes; the new raw value goes through debounce normally.

Decomposition:
- Package keypad_pkg:
  - KEY_STAR=4'hA, KEY_HASH=4'hB.
  - FSM state enum {RELEASE_WAIT, IDLE, PRESSED}.
  - Bitmap width constant KEYS=12.
- Sub-module keypad_debounce:
  - Parameters WIDTH and DEBOUNCE; ports clk, rst, en, raw, stable.
  - Reused later for other polled inputs.
- Encoder, FSM and entry buffer stay in keypad_entry.

Test Plan (DEBOUNCE=3, en=1 every cycle unless stated):
- Reset, zeros held 4 cycles, then numbers=10'h020 held 5 cycles -> exactly one key_valid with key_code=5, then hexx=0x0005, mask=0001.
- Keys 1,2,3,4,5, each pressed and released -> after the 4th: hexx=0x1234, mask=1111, points=1000; 5th press -> err pulse, hexx unchanged.
- numbers[7] toggling 1/0 every sample for 8 cycles -> no key_valid; then held 3 samples -> one event, code 7.
- Repeat the check with en pulsed every 4th cycle -> the event needs 3 en-samples, not 3 clocks.
- Enter 1,2; '*' -> hexx=0x0001, mask=0001. '*' twice more -> hexx=0, mask=0, no err.
- Enter 1,2,3; '#' -> value_valid one cycle with value=0x0123, then hexx=0, mask=0. '#' again -> err pulse, value stays 0x0123.
- numbers[1] and numbers[2] pressed together -> no event; release numbers[1] only -> no event; release all, press 2 -> event code 2.
- Assert rst while numbers[9] is held -> no event; release, then press 9 -> event code 9.
